// File: rtl/fp_mul_issue_if.sv
// Issue, multiplier and writeback signals of the FMUL.S front-end, bundled for port connection.
// slave = the issue block itself; master = the core/multiplier side that drives it.
interface fp_mul_issue_if #(
    parameter int TAG_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [TAG_W-1:0]  req_rd;
    logic              flush;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_p;
    logic [TAG_W-1:0]  rsp_rd;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, req_rd, flush, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_rd, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_rd, flush, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_rd, busy
    );
endinterface

// File: rtl/fp_mul_issue.sv
// Single-op FMUL.S issue front-end: result valid LAT cycles after accept, one op per LAT+1 back-to-back.
// Backpressure: result held until rsp_ready; a new request is taken only when idle or in the draining cycle.
module fp_mul_issue #(
    parameter int LAT   = 2,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_mul_issue_if.slave   io
);
    if (LAT < 1 || LAT > 15) begin : g_lat_range
        $error("fp_mul_issue: LAT must be within 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]      p;
        logic [TAG_W-1:0] rd;
    } rsp_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] tag;
    logic [31:0]      mul_a_q;
    logic [31:0]      mul_b_q;
    rsp_t             rsp_q;
    logic             rsp_vld_q;
    logic             req_rdy_c;
    logic             accept;

    // Flush wins over everything, so no request slips in during the flush cycle.
    always_comb begin
        req_rdy_c = 1'b0;
        if (!io.flush) begin
            case (state)
                IDLE:    req_rdy_c = 1'b1;
                DONE:    req_rdy_c = io.rsp_ready;
                default: req_rdy_c = 1'b0;
            endcase
        end
    end

    assign accept = io.req_valid && req_rdy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            tag       <= '0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            rsp_q     <= '0;
            rsp_vld_q <= 1'b0;
        end else if (io.flush) begin
            // Operands are left as-is; the multiplier output is simply ignored.
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_q     <= '{p: io.mul_p, rd: tag};
                        rsp_vld_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (io.rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the DONE->IDLE move when a new op arrives in the draining cycle.
            if (accept) begin
                mul_a_q <= io.req_a;
                mul_b_q <= io.req_b;
                tag     <= io.req_rd;
                cnt     <= CNT_INIT;
                state   <= EXEC;
            end
        end
    end

    assign io.req_ready = req_rdy_c;
    assign io.mul_a     = mul_a_q;
    assign io.mul_b     = mul_b_q;
    assign io.rsp_valid = rsp_vld_q;
    assign io.rsp_p     = rsp_q.p;
    assign io.rsp_rd    = rsp_q.rd;
    assign io.busy      = (state != IDLE);

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_vld_q && !io.rsp_ready && !io.flush) |=> (rsp_vld_q && $stable(rsp_q)));

    a_opnd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == EXEC) |=> ($stable(mul_a_q) && $stable(mul_b_q)));

    a_vld_in_done: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_vld_q == (state == DONE));
endmodule

// File: tb/tb_fp_mul_issue.sv
// Directed and randomized bench for fp_mul_issue; the bench also plays the combinational multiplier.
module tb_fp_mul_issue;
    localparam int LAT   = 2;
    localparam int TAG_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fp_mul_issue_if #(.TAG_W(TAG_W)) bus ();

    fp_mul_issue #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Simple single-precision multiply (denormals flushed, truncating) standing in for the datapath.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s, an, bn, ai, bi, az, bz;
        int          e;
        logic [47:0] m;
        logic [22:0] f;
        s  = a[31] ^ b[31];
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
        if (ai || bi) return {s, 8'hFF, 23'd0};
        if (az || bz) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            f = m[46:24];
        end else begin
            f = m[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), f};
    endfunction

    assign bus.mul_p = fmul(bus.mul_a, bus.mul_b);

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(7))
            0:       return {r[31], 31'd0};
            1:       return {r[31], 8'hFF, 23'd0};
            2:       return {r[31], 8'hFF, r[22:1], 1'b1};
            default: return r;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] rd);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
    endtask

    initial begin
        logic       infl, pv, pr, fl, rv, rr;
        int         acc_k;
        logic [31:0] ra, rb, ep;
        logic [TAG_W-1:0] rrd, erd;

        drive(1'b0, 32'd0, 32'd0, '0);
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset values, then ready once released
        #12;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_p", bus.rsp_p, 0);
        chk("rst_rsp_rd", bus.rsp_rd, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        step();

        // 3.0 x 2.0, rd=7, latency LAT
        drive(1'b1, 32'h40400000, 32'h40000000, 5'd7);
        step();
        drive(1'b0, 32'd0, 32'd0, '0);
        #1;
        chk("t1_busy_e0", bus.busy, 1);
        chk("t1_mul_a", bus.mul_a, 32'h40400000);
        chk("t1_mul_b", bus.mul_b, 32'h40000000);
        chk("t1_req_ready_exec", bus.req_ready, 0);
        chk("t1_vld_e0", bus.rsp_valid, 0);
        step();
        chk("t1_vld_e1", bus.rsp_valid, 0);
        step();
        chk("t1_vld_e2", bus.rsp_valid, 1);
        chk("t1_p", bus.rsp_p, 32'h40C00000);
        chk("t1_rd", bus.rsp_rd, 7);

        // Backpressure: hold for 5 cycles with a competing request present
        drive(1'b1, 32'h41200000, 32'h41200000, 5'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_vld", bus.rsp_valid, 1);
            chk("bp_p", bus.rsp_p, 32'h40C00000);
            chk("bp_rd", bus.rsp_rd, 7);
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_mul_a", bus.mul_a, 32'h40400000);
        end
        drive(1'b0, 32'd0, 32'd0, '0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_req_ready_drain", bus.req_ready, 1);
        step();
        chk("bp_vld_drop", bus.rsp_valid, 0);
        chk("bp_idle", bus.busy, 0);

        // Back-to-back: second op accepted in the draining cycle
        drive(1'b1, 32'h40400000, 32'h40000000, 5'd1);
        step();
        drive(1'b1, 32'h3F800000, 32'hBF800000, 5'd2);
        #1;
        chk("b2b_vld_e0", bus.rsp_valid, 0);
        step();
        chk("b2b_vld_e1", bus.rsp_valid, 0);
        step();
        chk("b2b_vld1", bus.rsp_valid, 1);
        chk("b2b_p1", bus.rsp_p, 32'h40C00000);
        chk("b2b_rd1", bus.rsp_rd, 1);
        step();
        drive(1'b0, 32'd0, 32'd0, '0);
        chk("b2b_vld_e3", bus.rsp_valid, 0);
        chk("b2b_busy_e3", bus.busy, 1);
        chk("b2b_mul_a2", bus.mul_a, 32'h3F800000);
        step();
        chk("b2b_vld_e4", bus.rsp_valid, 0);
        step();
        chk("b2b_vld2", bus.rsp_valid, 1);
        chk("b2b_p2", bus.rsp_p, 32'hBF800000);
        chk("b2b_rd2", bus.rsp_rd, 2);
        step();
        chk("b2b_idle", bus.busy, 0);

        // Inf x 0 passes the multiplier's NaN straight through
        drive(1'b1, 32'h7F800000, 32'h00000000, 5'd3);
        step();
        drive(1'b0, 32'd0, 32'd0, '0);
        step();
        step();
        chk("nan_vld", bus.rsp_valid, 1);
        chk("nan_p", bus.rsp_p, 32'h7FC00000);
        chk("nan_rd", bus.rsp_rd, 3);
        step();

        // Flush one cycle after accept, with a request waiting
        drive(1'b1, 32'h40400000, 32'h40400000, 5'd9);
        step();
        drive(1'b1, 32'h41000000, 32'h41000000, 5'd10);
        bus.flush = 1'b1;
        #1;
        chk("fl_req_ready", bus.req_ready, 0);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, '0);
        chk("fl_busy", bus.busy, 0);
        chk("fl_vld", bus.rsp_valid, 0);
        chk("fl_mul_a_kept", bus.mul_a, 32'h40400000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_rsp", bus.rsp_valid, 0);
        end
        drive(1'b1, 32'h3FC00000, 32'h3FC00000, 5'd12);
        step();
        drive(1'b0, 32'd0, 32'd0, '0);
        step();
        step();
        chk("fl_next_vld", bus.rsp_valid, 1);
        chk("fl_next_p", bus.rsp_p, 32'h40100000);
        chk("fl_next_rd", bus.rsp_rd, 12);
        step();

        // Async reset while holding a result in DONE
        bus.rsp_ready = 1'b0;
        drive(1'b1, 32'h40000000, 32'h40000000, 5'd5);
        step();
        drive(1'b0, 32'd0, 32'd0, '0);
        step();
        step();
        chk("ar_vld_before", bus.rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", bus.rsp_valid, 0);
        chk("ar_p", bus.rsp_p, 0);
        chk("ar_rd", bus.rsp_rd, 0);
        chk("ar_mul_a", bus.mul_a, 0);
        chk("ar_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("ar_req_ready", bus.req_ready, 1);
        step();
        chk("ar_no_rsp", bus.rsp_valid, 0);

        // Randomized traffic against a transaction-level model
        infl  = 1'b0;
        acc_k = 0;
        ep    = 32'd0;
        erd   = '0;
        for (int k = 0; k < 400; k++) begin
            fl  = ($urandom_range(31) == 0);
            rv  = ($urandom_range(2) != 0);
            rr  = ($urandom_range(3) != 0);
            ra  = rand_fp();
            rb  = rand_fp();
            rrd = TAG_W'($urandom);
            drive(rv, ra, rb, rrd);
            bus.flush     = fl;
            bus.rsp_ready = rr;
            #1;
            pv = infl && (k >= acc_k + LAT);
            pr = !fl && (!infl || (pv && rr));
            chk("rnd_vld", bus.rsp_valid, pv);
            chk("rnd_req_ready", bus.req_ready, pr);
            chk("rnd_busy", bus.busy, infl);
            if (pv) begin
                chk("rnd_p", bus.rsp_p, ep);
                chk("rnd_rd", bus.rsp_rd, erd);
            end
            if (fl) begin
                infl = 1'b0;
            end else begin
                if (pv && rr) infl = 1'b0;
                if (rv && pr) begin
                    infl  = 1'b1;
                    acc_k = k + 1;
                    ep    = fmul(ra, rb);
                    erd   = rrd;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_issue.md
Name: fp_mul_issue

Overview:
- Sequential front-end for the single-precision FP multiplier datapath: accepts FMUL.S requests from the core decode/issue stage over valid/ready.
- Registers the operands that drive the combinational multiplier and allows a fixed multicycle settle window of LAT cycles.
- Captures the product and presents it with its destination tag to FP writeback over valid/ready.
- Single in-flight operation; supports pipeline flush.

Parameters:
- LAT, 2: cycles from request acceptance to result capture; legal range 1..15.
- TAG_W, 5: width of the destination register tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  issue stage presents a request.
- req_ready  out  1  block accepts a request this cycle.
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B, IEEE-754 single.
- req_rd  in  TAG_W  destination tag.
- flush  in  1  discard in-flight and pending work.
- mul_a  out  32  registered operand A to the multiplier.
- mul_b  out  32  registered operand B to the multiplier.
- mul_p  in  32  product from the multiplier (combinational from mul_a/mul_b).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  writeback accepts the result.
- rsp_p  out  32  registered product.
- rsp_rd  out  TAG_W  destination tag of rsp_p.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; counter 0.
  - mul_a, mul_b, rsp_p and rsp_rd are 0; rsp_valid is 0.
  - req_ready is 1 once rst_n is high; busy is 0.
- State IDLE:
  - req_ready=1.
  - On req_valid && req_ready: load mul_a=req_a, mul_b=req_b and the tag register=req_rd; counter=LAT-1; go to EXEC.
- State EXEC:
  - req_ready=0; mul_a/mul_b held stable.
  - While counter!=0: decrement it.
  - At the edge where counter==0: rsp_p<=mul_p, rsp_rd<=tag, rsp_valid<=1; go to DONE.
  - Timing: the accept edge is edge 0 and rsp_valid rises after edge LAT. With LAT=1, mul_p settles for one full cycle.
- State DONE:
  - rsp_valid=1; rsp_p and rsp_rd are stable until the handshake.
  - req_ready = rsp_ready (combinational).
  - rsp_valid && rsp_ready with no new request: rsp_valid<=0; go to IDLE.
  - rsp_valid && rsp_ready with req_valid in the same cycle: drain and accept together; load the new operands and counter as in IDLE; go to EXEC. This gives back-to-back throughput of one op per LAT+1 cycles.
  - No rsp_ready: hold indefinitely, with no change to any output.
- Flush:
  - Highest priority in every state; req_ready=0 during the flush cycle.
  - Next state IDLE; rsp_valid<=0; counter<=0; no request is accepted that cycle.
  - mul_a/mul_b keep their last value (not cleared).
- Async reset mid-EXEC or mid-DONE: immediate return to reset values; the in-flight result is lost and never appears on rsp.
- Width rules:
  - The counter is 4 bits.
  - The product is passed through unmodified; special values (NaN/Inf/zero) are the multiplier's responsibility.
  - Tag and product are captured together, so rsp_rd always matches the rsp_p it accompanies.
- Protocol rules:
  - Once rsp_valid is high, it stays high until the handshake or a flush.
  - rsp_valid never depends combinationally on rsp_ready.
  - req_ready never depends combinationally on req_valid.

Test Plan:
- LAT=2: accept A=0x40400000 (3.0), B=0x40000000 (2.0), rd=7 at edge 0 → rsp_valid high after edge 2, rsp_p=0x40C00000, rsp_rd=7, busy high from edge 0 until the handshake.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_p, rsp_rd and rsp_valid stable; req_ready=0 throughout; rsp_ready=1 → rsp_valid drops next edge and the state is IDLE.
- Back-to-back: hold req_valid=1 with 3.0×2.0 (rd=1) then 0x3F800000×0xBF800000 (rd=2), rsp_ready=1 → responses 0x40C00000/1 then 0xBF800000/2, issued 3 cycles apart at LAT=2.
- Special value: A=0x7F800000 (+Inf), B=0x00000000 → rsp_p=0x7FC00000 (multiplier's canonical NaN) after LAT cycles.
- Flush mid-EXEC one cycle after accept → busy=0 next edge; rsp_valid never asserts; a subsequent request completes normally with correct rd.
- Reset: assert rst_n=0 asynchronously in DONE → rsp_valid=0, rsp_p=0 and mul_a=0 immediately without a clock edge; req_ready=1 after release.
